// File: rtl/alu_op_sequencer.sv
// Sequences the ALU datapath controls and register writeback for one operation at a time.
// Define ALU_OP_SEQUENCER_PIPE_EN to accept the next request during writeback (back-to-back issue).
module alu_op_sequencer #(
    parameter int TAM = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [3:0] op_ra,
    input  logic [3:0] op_rb,
    input  logic [3:0] op_rd,
    output logic [3:0] sel_a,
    output logic [3:0] sel_b,
    output logic       cmp2,
    output logic       incdec,
    output logic [1:0] alu_fn,
    output logic       alu_cin,
    output logic       tmp_we,
    output logic       wb_en,
    output logic [3:0] wb_addr,
    output logic       busy,
    output logic       err
);

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] TMP_IDX = 4'hF;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_AND = 2'b01;
    localparam logic [1:0] FN_OR  = 2'b10;
    localparam logic [1:0] FN_NOT = 2'b11;

`ifdef ALU_OP_SEQUENCER_PIPE_EN
    localparam bit PIPE_EN = 1'b1;
`else
    localparam bit PIPE_EN = 1'b0;
`endif

    // The datapath has to be at least as wide as a register index.
    if (TAM < IDX_W) begin : g_tam_check
        $error("alu_op_sequencer: TAM must be at least %0d", IDX_W);
    end

    typedef enum logic [1:0] {
        IDLE,
        EXEC1,
        EXEC2,
        WB
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] sel_a;
        logic [IDX_W-1:0] sel_b;
        logic             cmp2;
        logic             incdec;
        logic [1:0]       alu_fn;
        logic             alu_cin;
        logic             tmp_we;
        logic             wb_en;
        logic [IDX_W-1:0] wb_addr;
        logic             busy;
    } ctrl_t;

    state_t           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [IDX_W-1:0] ra_q, ra_d;
    logic [IDX_W-1:0] rb_q, rb_d;
    logic [IDX_W-1:0] rd_q, rd_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             err_q, err_d;
    logic             accept;

    // First execute cycle; SUB forms ~rb into the temp register here.
    function automatic ctrl_t exec1_ctrl(input logic [2:0] code,
                                         input logic [IDX_W-1:0] ra,
                                         input logic [IDX_W-1:0] rb);
        ctrl_t c;
        c      = '0;
        c.busy = 1'b1;
        case (code)
            OP_ADD: begin
                c.sel_a  = ra;
                c.sel_b  = rb;
                c.alu_fn = FN_ADD;
            end
            OP_AND: begin
                c.sel_a  = ra;
                c.sel_b  = rb;
                c.alu_fn = FN_AND;
            end
            OP_OR: begin
                c.sel_a  = ra;
                c.sel_b  = rb;
                c.alu_fn = FN_OR;
            end
            OP_NOT: begin
                c.sel_a  = ra;
                c.alu_fn = FN_NOT;
            end
            OP_INC: begin
                c.sel_a  = ra;
                c.incdec = 1'b1;
                c.alu_fn = FN_ADD;
            end
            OP_DEC: begin
                c.sel_b  = ra;
                c.cmp2   = 1'b1;
                c.alu_fn = FN_ADD;
            end
            OP_SUB: begin
                c.sel_a  = rb;
                c.alu_fn = FN_NOT;
                c.tmp_we = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Second SUB cycle: ra + temp(~rb) + 1.
    function automatic ctrl_t exec2_ctrl(input logic [IDX_W-1:0] ra);
        ctrl_t c;
        c         = '0;
        c.busy    = 1'b1;
        c.sel_a   = ra;
        c.sel_b   = TMP_IDX;
        c.alu_fn  = FN_ADD;
        c.alu_cin = 1'b1;
        return c;
    endfunction

    assign op_ready = (state_q == IDLE) || (PIPE_EN && (state_q == WB));
    assign accept   = op_valid && op_ready;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE:    state_d = IDLE;
            EXEC1:   state_d = (code_q == OP_SUB) ? EXEC2 : WB;
            EXEC2:   state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Accept only happens in IDLE, or in WB when back-to-back issue is enabled.
        if (accept) begin
            code_d = op_code;
            ra_d   = op_ra;
            rb_d   = op_rb;
            rd_d   = op_rd;
            if (op_code == OP_RSV) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = EXEC1;
            end
        end
    end

    // Outputs are computed for the upcoming state so they can be registered directly.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            EXEC1: ctrl_d = exec1_ctrl(code_d, ra_d, rb_d);
            EXEC2: ctrl_d = exec2_ctrl(ra_d);
            WB: begin
                ctrl_d = (code_d == OP_SUB) ? exec2_ctrl(ra_d)
                                            : exec1_ctrl(code_d, ra_d, rb_d);
                ctrl_d.wb_en   = 1'b1;
                ctrl_d.wb_addr = rd_d;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
        end
    end

    assign sel_a   = ctrl_q.sel_a;
    assign sel_b   = ctrl_q.sel_b;
    assign cmp2    = ctrl_q.cmp2;
    assign incdec  = ctrl_q.incdec;
    assign alu_fn  = ctrl_q.alu_fn;
    assign alu_cin = ctrl_q.alu_cin;
    assign tmp_we  = ctrl_q.tmp_we;
    assign wb_en   = ctrl_q.wb_en;
    assign wb_addr = ctrl_q.wb_addr;
    assign busy    = ctrl_q.busy;
    assign err     = err_q;

    a_operand_force_exclusive: assert property (@(posedge clk) disable iff (rst) !(cmp2 && incdec));
    a_tmp_wb_exclusive: assert property (@(posedge clk) disable iff (rst) !(tmp_we && wb_en));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vector table, multi-cycle corner cases and
// a randomized run scored against a per-cycle schedule queue and an arithmetic datapath model.
module tb_alu_op_sequencer;

`ifdef ALU_OP_SEQUENCER_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [3:0] op_ra, op_rb, op_rd;
    logic [3:0] sel_a, sel_b;
    logic       cmp2, incdec;
    logic [1:0] alu_fn;
    logic       alu_cin, tmp_we, wb_en;
    logic [3:0] wb_addr;
    logic       busy, err;

    always #5 clk = ~clk;

    alu_op_sequencer #(.TAM(16)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_ra(op_ra), .op_rb(op_rb), .op_rd(op_rd),
        .sel_a(sel_a), .sel_b(sel_b), .cmp2(cmp2), .incdec(incdec),
        .alu_fn(alu_fn), .alu_cin(alu_cin), .tmp_we(tmp_we),
        .wb_en(wb_en), .wb_addr(wb_addr), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [3:0] sel_a;
        logic [3:0] sel_b;
        logic       cmp2;
        logic       incdec;
        logic [1:0] alu_fn;
        logic       alu_cin;
        logic       tmp_we;
        logic       wb_en;
        logic [3:0] wb_addr;
        logic       busy;
        logic       err;
    } out_t;

    typedef struct {
        logic [2:0] code;
        logic [3:0] ra, rb, rd;
        logic [3:0] sel_a, sel_b;
        logic       cmp2, incdec;
        logic [1:0] fn;
        logic       tmp_we, err;
        int         lat;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    out_t        sched[$];
    logic [15:0] results[$];
    logic [15:0] regs [0:15];
    logic [15:0] tmp;

    task automatic checkOutput(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] code,
                                 input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd);
        op_valid = v;
        op_code  = code;
        op_ra    = ra;
        op_rb    = rb;
        op_rd    = rd;
    endtask

    function automatic out_t sampleDut();
        out_t o;
        o = '{sel_a, sel_b, cmp2, incdec, alu_fn, alu_cin, tmp_we, wb_en, wb_addr, busy, err};
        return o;
    endfunction

    task automatic checkAll(input string tag, input out_t want);
        out_t got;
        got = sampleDut();
        checkOutput({tag, ".sel_a"},   int'(got.sel_a),   int'(want.sel_a));
        checkOutput({tag, ".sel_b"},   int'(got.sel_b),   int'(want.sel_b));
        checkOutput({tag, ".cmp2"},    int'(got.cmp2),    int'(want.cmp2));
        checkOutput({tag, ".incdec"},  int'(got.incdec),  int'(want.incdec));
        checkOutput({tag, ".alu_fn"},  int'(got.alu_fn),  int'(want.alu_fn));
        checkOutput({tag, ".alu_cin"}, int'(got.alu_cin), int'(want.alu_cin));
        checkOutput({tag, ".tmp_we"},  int'(got.tmp_we),  int'(want.tmp_we));
        checkOutput({tag, ".wb_en"},   int'(got.wb_en),   int'(want.wb_en));
        checkOutput({tag, ".wb_addr"}, int'(got.wb_addr), int'(want.wb_addr));
        checkOutput({tag, ".busy"},    int'(got.busy),    int'(want.busy));
        checkOutput({tag, ".err"},     int'(got.err),     int'(want.err));
    endtask

    // Control word the ALU needs in the first execute cycle of each opcode.
    function automatic out_t exec1Ctl(input logic [2:0] code, input logic [3:0] ra, input logic [3:0] rb);
        out_t e;
        e = '0;
        e.busy = 1'b1;
        case (code)
            OP_ADD: begin e.sel_a = ra; e.sel_b = rb; e.alu_fn = 2'b00; end
            OP_AND: begin e.sel_a = ra; e.sel_b = rb; e.alu_fn = 2'b01; end
            OP_OR:  begin e.sel_a = ra; e.sel_b = rb; e.alu_fn = 2'b10; end
            OP_NOT: begin e.sel_a = ra; e.alu_fn = 2'b11; end
            OP_INC: begin e.sel_a = ra; e.incdec = 1'b1; end
            OP_DEC: begin e.sel_b = ra; e.cmp2 = 1'b1; end
            OP_SUB: begin e.sel_a = rb; e.alu_fn = 2'b11; e.tmp_we = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Appends the expected output word of every cycle the accepted request occupies.
    task automatic pushOp(input logic [2:0] code, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd);
        out_t e;
        if (code == OP_RSV) begin
            e = '0;
            e.err = 1'b1;
            sched.push_back(e);
        end else begin
            e = exec1Ctl(code, ra, rb);
            sched.push_back(e);
            if (code == OP_SUB) begin
                e = '0;
                e.busy = 1'b1;
                e.sel_a = ra;
                e.sel_b = 4'hF;
                e.alu_cin = 1'b1;
                sched.push_back(e);
            end
            e.wb_en = 1'b1;
            e.wb_addr = rd;
            sched.push_back(e);
        end
    endtask

    function automatic logic [15:0] srcVal(input logic [3:0] s);
        return (s == 4'hF) ? tmp : regs[s];
    endfunction

    function automatic logic [15:0] refResult(input logic [2:0] code, input logic [3:0] ra, input logic [3:0] rb);
        logic [15:0] a, b;
        a = srcVal(ra);
        b = srcVal(rb);
        case (code)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_INC:  return a + 16'd1;
            OP_DEC:  return a - 16'd1;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return ~a;
        endcase
    endfunction

    // What a datapath wired to the DUT controls would produce this cycle.
    function automatic logic [15:0] dpEval();
        logic [15:0] a, b;
        a = cmp2 ? 16'hFFFF : srcVal(sel_a);
        b = incdec ? 16'd1 : srcVal(sel_b);
        case (alu_fn)
            2'b00:   return a + b + {15'd0, alu_cin};
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return ~a;
        endcase
    endfunction

    initial begin
        vec_t        vecs[10];
        vec_t        v;
        out_t        want;
        int          n, first, second, wbCount, weCount, busyCount;
        logic        readyExp, rv;
        logic [2:0]  rc;
        logic [3:0]  ra, rb, rd;
        logic [15:0] res;

        vecs[0] = '{OP_ADD, 4'd2,  4'd3,  4'd4,  4'd2,  4'd3,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2};
        vecs[1] = '{OP_SUB, 4'd5,  4'd6,  4'd7,  4'd6,  4'd0,  1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 3};
        vecs[2] = '{OP_INC, 4'd1,  4'd9,  4'd8,  4'd1,  4'd0,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2};
        vecs[3] = '{OP_DEC, 4'd1,  4'd9,  4'd8,  4'd0,  4'd1,  1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2};
        vecs[4] = '{OP_AND, 4'd10, 4'd11, 4'd12, 4'd10, 4'd11, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2};
        vecs[5] = '{OP_OR,  4'd13, 4'd14, 4'd0,  4'd13, 4'd14, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2};
        vecs[6] = '{OP_NOT, 4'd15, 4'd3,  4'd15, 4'd15, 4'd0,  1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2};
        vecs[7] = '{OP_RSV, 4'd1,  4'd2,  4'd3,  4'd0,  4'd0,  1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 0};
        vecs[8] = '{OP_ADD, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2};
        vecs[9] = '{OP_SUB, 4'd15, 4'd15, 4'd0,  4'd15, 4'd0,  1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 3};

        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        tmp = 16'($urandom);

        rst = 1'b1;
        applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        checkAll("reset", '0);
        checkOutput("reset.op_ready", int'(op_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        checkAll("idle", '0);

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            applyStimulus(1'b1, v.code, v.ra, v.rb, v.rd);
            @(negedge clk);
            applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0);
            checkOutput($sformatf("vec%0d.sel_a", i),    int'(sel_a),    int'(v.sel_a));
            checkOutput($sformatf("vec%0d.sel_b", i),    int'(sel_b),    int'(v.sel_b));
            checkOutput($sformatf("vec%0d.cmp2", i),     int'(cmp2),     int'(v.cmp2));
            checkOutput($sformatf("vec%0d.incdec", i),   int'(incdec),   int'(v.incdec));
            checkOutput($sformatf("vec%0d.alu_fn", i),   int'(alu_fn),   int'(v.fn));
            checkOutput($sformatf("vec%0d.tmp_we", i),   int'(tmp_we),   int'(v.tmp_we));
            checkOutput($sformatf("vec%0d.err", i),      int'(err),      int'(v.err));
            checkOutput($sformatf("vec%0d.op_ready", i), int'(op_ready), (v.lat == 0) ? 1 : 0);
            n = 1;
            while (!wb_en && n < 6) begin
                @(negedge clk);
                n++;
            end
            checkOutput($sformatf("vec%0d.latency", i), wb_en ? n : 0, v.lat);
            if (wb_en) checkOutput($sformatf("vec%0d.wb_addr", i), int'(wb_addr), int'(v.rd));
            @(negedge clk);
            checkOutput($sformatf("vec%0d.after_ready", i), int'(op_ready), 1);
            checkOutput($sformatf("vec%0d.after_busy", i),  int'(busy),     0);
            checkOutput($sformatf("vec%0d.after_err", i),   int'(err),      0);
        end

        // SUB second cycle and the held controls during its writeback.
        applyStimulus(1'b1, OP_SUB, 4'd5, 4'd6, 4'd7);
        @(negedge clk);
        applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        want = '{4'd5, 4'hF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        checkAll("sub.exec2", want);
        @(negedge clk);
        want.wb_en = 1'b1;
        want.wb_addr = 4'd7;
        checkAll("sub.wb", want);
        @(negedge clk);

        // Reset in EXEC2 of a SUB aborts it immediately.
        applyStimulus(1'b1, OP_SUB, 4'd3, 4'd4, 4'd9);
        @(negedge clk);
        applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        checkOutput("rst_exec2.pre_sel_b", int'(sel_b), 15);
        #2 rst = 1'b1;
        #1;
        checkAll("rst_exec2.now", '0);
        checkOutput("rst_exec2.op_ready", int'(op_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        wbCount = 0;
        weCount = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wb_en) wbCount++;
            if (tmp_we) weCount++;
        end
        checkOutput("rst_exec2.no_wb", wbCount, 0);
        checkOutput("rst_exec2.no_tmp_we", weCount, 0);

        // A request held during reset is not taken.
        rst = 1'b1;
        applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0);
        rst = 1'b0;
        busyCount = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (busy || wb_en) busyCount++;
        end
        checkOutput("rst_valid.ignored", busyCount, 0);

        // Two ADDs with op_valid held high: spacing of the writeback pulses.
        applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3);
        first = -1;
        second = -1;
        for (int c = 0; c < 12 && second < 0; c++) begin
            @(negedge clk);
            if (wb_en) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0);
        checkOutput("b2b.spacing", (second < 0) ? -1 : second - first, PIPE ? 2 : 3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || err) && n < 8);
        checkOutput("b2b.drained", int'(busy), 0);

        // Randomized run against the schedule queue and the arithmetic model.
        sched.delete();
        results.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc != 0) @(negedge clk);
            want = (sched.size() > 0) ? sched.pop_front() : '0;
            checkAll("rand", want);
            readyExp = !want.busy || (PIPE && want.wb_en);
            checkOutput("rand.op_ready", int'(op_ready), int'(readyExp));
            res = dpEval();
            if (wb_en) begin
                checkOutput("rand.wb_pending", results.size(), 1);
                if (results.size() > 0) checkOutput("rand.wb_value", int'(res), int'(results.pop_front()));
            end
            if (tmp_we) tmp = res;
            rv = ($urandom_range(0, 99) < 60);
            rc = 3'($urandom_range(0, 7));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rd = 4'($urandom_range(0, 15));
            if (rc == OP_SUB && ra == 4'hF) ra = 4'($urandom_range(0, 14));
            applyStimulus(rv, rc, ra, rb, rd);
            if (rv && readyExp) begin
                pushOp(rc, ra, rb, rd);
                if (rc != OP_RSV) results.push_back(refResult(rc, ra, rb));
            end
        end

        applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
